// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the sequenced ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_SHR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned WIDTH x WIDTH multiplier. ALU_SEQ_MUL_EN selects an iterative
// shift-add unit (WIDTH steps); otherwise a single-cycle combinational product.
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               done,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] part;

  // Operands are held stable by the caller for the whole run, so one partial
  // product per cycle is added; the last one is folded into product directly.
  always_comb begin
    part    = b[cnt_q] ? ({{WIDTH{1'b0}}, a} << cnt_q) : '0;
    done    = run_q && (cnt_q == CW'(WIDTH - 1));
    product = acc_q + part;
    cnt_d   = cnt_q;
    run_d   = run_q;
    acc_d   = acc_q;
    if (start) begin
      cnt_d = '0;
      run_d = 1'b1;
      acc_d = '0;
    end else if (run_q) begin
      acc_d = acc_q + part;
      cnt_d = cnt_q + 1'b1;
      if (done) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      acc_q <= acc_d;
    end
  end
`else
  logic unused_ok;

  assign product   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign done      = 1'b1;
  assign unused_ok = ^{clk, reset, start};
`endif

endmodule

// File: rtl/alu_seq.sv
// Request/response ALU with an IDLE/EXEC/DONE sequencer.
// Build option: ALU_SEQ_MUL_EN makes MUL iterative (WIDTH cycles in EXEC).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         sel,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid,
  output logic [1:0]         selected_op,
  output logic               busy
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic [2*WIDTH-1:0] res, mul_prod;
  logic               accept, mul_start, mul_done, res_ok;

  assign accept    = in_valid && (state_q == S_IDLE);
  assign mul_start = accept && (op_e'(sel) == OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .done    (mul_done),
    .a       (a_q),
    .b       (b_q),
    .product (mul_prod)
  );

  always_comb begin
    res = '0;
    unique case (op_q)
      OP_ADD: res = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
      OP_SUB: res = {{WIDTH{a_q < b_q}}, a_q - b_q};
      OP_MUL: res = mul_prod;
      OP_SHR: res = (b_q >= WIDTH'(WIDTH)) ? '0 : {{WIDTH{1'b0}}, a_q >> b_q};
      default: res = '0;
    endcase
  end

  assign res_ok = (op_q != OP_MUL) || mul_done;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        op_d    = op_e'(sel);
        a_d     = a;
        b_d     = b;
        state_d = S_EXEC;
      end
      S_EXEC: if (res_ok) begin
        out_d   = res;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign selected_op = op_q;
  assign out         = out_q;

endmodule
